// File: rtl/mem_pwr_pkg.sv
// Shared types for the banked-SRAM power sequencer.
package mem_pwr_pkg;

    typedef enum logic [1:0] {
        BANK_SLEEP  = 2'd0,
        BANK_WAKING = 2'd1,
        BANK_ON     = 2'd2
    } bank_state_e;

endpackage

// File: rtl/mem_bank_pwr_fsm.sv
// Per-bank power FSM: SLEEP -> WAKING (fixed latency) -> ON -> SLEEP after idle timeout.
module mem_bank_pwr_fsm
    import mem_pwr_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64,
    parameter int WAKE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    input  logic       access,
    input  logic       force_sleep,
    output logic [1:0] state,
    output logic       sleep
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

    bank_state_e   state_q, state_nxt;
    logic [IW-1:0] idle_q, idle_nxt;
    logic [WW-1:0] wake_q, wake_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_SLEEP;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_nxt;
            idle_q  <= idle_nxt;
            wake_q  <= wake_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        idle_nxt  = idle_q;
        wake_nxt  = wake_q;
        case (state_q)
            BANK_SLEEP: begin
                if (hit) begin
                    state_nxt = BANK_WAKING;
                    wake_nxt  = '0;
                end
            end
            BANK_WAKING: begin
                if (wake_q == WAKE_LAST) begin
                    state_nxt = BANK_ON;
                    idle_nxt  = '0;
                end else begin
                    wake_nxt = wake_q + 1'b1;
                end
            end
            BANK_ON: begin
                // An access in the expiry cycle keeps the bank on.
                if (access) begin
                    idle_nxt = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_nxt = BANK_SLEEP;
                end else if (idle_q != '1) begin
                    idle_nxt = idle_q + 1'b1;
                end
            end
            default: state_nxt = BANK_SLEEP;
        endcase
        if (force_sleep) begin
            state_nxt = BANK_SLEEP;
        end
    end

    assign state = state_q;
    assign sleep = (state_q == BANK_SLEEP);

endmodule

// File: rtl/mem_power_sequencer.sv
// Power sequencer and access gate for a banked SRAM: wakes the addressed bank on
// demand, sleeps idle banks, and holds requests off until the target bank is ON.
module mem_power_sequencer
    import mem_pwr_pkg::*;
#(
    parameter  int NUM_BANKS    = 4,
    parameter  int BANK_SIZE    = 256,
    parameter  int WIDTH        = 32,
    parameter  int IDLE_TIMEOUT = 64,
    parameter  int WAKE_CYCLES  = 4,
    localparam int AW           = $clog2(NUM_BANKS * BANK_SIZE),
    localparam int BW           = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 force_sleep,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [AW-1:0]        req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 mem_wr_en,
    output logic [AW-1:0]        mem_addr,
    output logic [WIDTH-1:0]     mem_wr_data,
    output logic [NUM_BANKS-1:0] bank_sleep,
    output logic                 all_asleep
);

    // Handshake: a transfer happens in any cycle with req_valid && req_ready.
    // req_ready never looks at req_valid; it only reflects that the addressed
    // bank is ON and no global sleep is requested. The requester holds
    // valid/wr/addr/wdata stable until the transfer.

    logic [BW-1:0]        bank_sel;
    logic [NUM_BANKS-1:0] hit;
    logic [NUM_BANKS-1:0] access;
    logic [1:0]           bank_state [NUM_BANKS];

    assign bank_sel = req_addr[AW-1 -: BW];

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign hit[i]    = req_valid && (bank_sel == BW'(i));
        assign access[i] = hit[i] && req_ready;

        mem_bank_pwr_fsm #(
            .IDLE_TIMEOUT (IDLE_TIMEOUT),
            .WAKE_CYCLES  (WAKE_CYCLES)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .hit         (hit[i]),
            .access      (access[i]),
            .force_sleep (force_sleep),
            .state       (bank_state[i]),
            .sleep       (bank_sleep[i])
        );
    end

    assign req_ready   = (bank_state[bank_sel] == BANK_ON) && !force_sleep;
    assign mem_wr_en   = req_valid && req_ready && req_wr;
    assign mem_addr    = req_addr;
    assign mem_wr_data = req_wdata;
    assign all_asleep  = &bank_sleep;

endmodule

// File: tb/tb_mem_power_sequencer.sv
// Directed bench for mem_power_sequencer: table-driven wake/write/idle vectors
// followed by hand-written keep-alive, timeout-edge, force_sleep and reset sequences.
module tb_mem_power_sequencer;

    localparam int W = 42;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        force_sleep;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        mem_wr_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  bank_sleep;
    logic        all_asleep;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = -1;
    logic [W-1:0] exp_q[$];

    mem_power_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .force_sleep (force_sleep),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .bank_sleep  (bank_sleep),
        .all_asleep  (all_asleep)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        fs;
        logic        v;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        er;
        logic        ew;
        logic [3:0]  es;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1 ns later.
    // Any write issued is matched against the scoreboard queue.
    task automatic step(input logic fs, input logic v, input logic wr,
                        input logic [9:0] a, input logic [31:0] d);
        logic [W-1:0] exp_w;
        @(negedge clk);
        force_sleep = fs;
        req_valid   = v;
        req_wr      = wr;
        req_addr    = a;
        req_wdata   = d;
        #1;
        cyc++;
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'd0, mem_addr, mem_wr_data}, 64'd0);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_data", {22'd0, mem_addr, mem_wr_data}, {22'd0, exp_w});
            end
        end
    endtask

    task automatic expect_out(input string name, input logic er, input logic ew, input logic [3:0] es);
        check({name, ".req_ready"},  {63'd0, req_ready},  {63'd0, er});
        check({name, ".mem_wr_en"},  {63'd0, mem_wr_en},  {63'd0, ew});
        check({name, ".bank_sleep"}, {60'd0, bank_sleep}, {60'd0, es});
        check({name, ".all_asleep"}, {63'd0, all_asleep}, {63'd0, &es});
        check({name, ".mem_addr"},   {54'd0, mem_addr},   {54'd0, req_addr});
    endtask

    // Hold one request until accepted; lat is the index of the accepting cycle.
    task automatic wait_ready(input logic fs, input logic wr, input logic [9:0] a,
                              input logic [31:0] d, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            step(fs, 1'b1, wr, a, d);
            if (req_ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            check("ready_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        int lat;

        vt[0]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 4'b1111};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 4'b1110};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 4'b1110};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 4'b1110};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b0, 1'b0, 4'b1110};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 4'b1110};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 4'b1110};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1110};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1010};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1010};
        vt[10] = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1010};
        vt[11] = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b0, 1'b0, 4'b1010};
        vt[12] = '{1'b0, 1'b1, 1'b1, 10'h200, 32'hA5A5A5A5, 1'b1, 1'b1, 4'b1010};
        vt[13] = '{1'b0, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1, 1'b0, 4'b1010};

        // reset
        rst_n       = 1'b0;
        force_sleep = 1'b0;
        req_valid   = 1'b0;
        req_wr      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 1'b0, 1'b0, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // wake bank 0, read; wake bank 2, write
        exp_q.push_back({10'h200, 32'hA5A5A5A5});
        for (int i = 0; i < 14; i++) begin
            step(vt[i].fs, vt[i].v, vt[i].wr, vt[i].addr, vt[i].wdata);
            expect_out($sformatf("vec%0d", i), vt[i].er, vt[i].ew, vt[i].es);
        end

        // idle: bank 0 (last access cyc 5) sleeps at 70, bank 2 (cyc 12) at 77
        while (cyc < 80) begin
            step(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
            expect_out("idle_timeout", (cyc < 70),  1'b0,
                       {1'b1, (cyc >= 77), 1'b1, (cyc >= 70)});
        end

        // bank 1 accessed every 63 cycles stays on
        wait_ready(1'b0, 1'b0, 10'h100, 32'h0, 10, lat);
        check("bank1_wake_latency", 64'(lat), 64'd5);
        for (int k = 0; k < 3; k++) begin
            repeat (62) begin
                step(1'b0, 1'b0, 1'b0, 10'h000, 32'h0);
                expect_out("keepalive_idle", 1'b0, 1'b0, 4'b1101);
            end
            step(1'b0, 1'b1, 1'b0, 10'h100, 32'h0);
            expect_out("keepalive_access", 1'b1, 1'b0, 4'b1101);
        end

        // access exactly on the expiry cycle, then a full fresh timeout
        repeat (63) begin
            step(1'b0, 1'b0, 1'b0, 10'h100, 32'h0);
            check("pre_edge_sleep", {60'd0, bank_sleep}, {60'd0, 4'b1101});
        end
        step(1'b0, 1'b1, 1'b0, 10'h100, 32'h0);
        expect_out("edge_access", 1'b1, 1'b0, 4'b1101);
        repeat (64) begin
            step(1'b0, 1'b0, 1'b0, 10'h100, 32'h0);
            check("post_edge_on", {60'd0, bank_sleep}, {60'd0, 4'b1101});
        end
        step(1'b0, 1'b0, 1'b0, 10'h100, 32'h0);
        expect_out("post_edge_sleep", 1'b0, 1'b0, 4'b1111);

        // force_sleep while bank 3 is waking with a write pending
        step(1'b0, 1'b1, 1'b1, 10'h300, 32'h3C3C_0F0F);
        expect_out("fs_req", 1'b0, 1'b0, 4'b1111);
        repeat (2) begin
            step(1'b0, 1'b1, 1'b1, 10'h300, 32'h3C3C_0F0F);
            expect_out("fs_waking", 1'b0, 1'b0, 4'b0111);
        end
        step(1'b1, 1'b1, 1'b1, 10'h300, 32'h3C3C_0F0F);
        expect_out("fs_rise", 1'b0, 1'b0, 4'b0111);
        repeat (3) begin
            step(1'b1, 1'b1, 1'b1, 10'h300, 32'h3C3C_0F0F);
            expect_out("fs_held", 1'b0, 1'b0, 4'b1111);
        end
        exp_q.push_back({10'h300, 32'h3C3C_0F0F});
        wait_ready(1'b0, 1'b1, 10'h300, 32'h3C3C_0F0F, 10, lat);
        check("fs_rewake_latency", 64'(lat), 64'd5);
        check("fs_accept_wr_en", {63'd0, mem_wr_en}, 64'd1);
        check("fs_accept_sleep", {60'd0, bank_sleep}, {60'd0, 4'b0111});
        step(1'b0, 1'b0, 1'b0, 10'h300, 32'h0);
        expect_out("fs_after", 1'b1, 1'b0, 4'b0111);

        // asynchronous reset in the middle of a bank-2 wake
        step(1'b0, 1'b1, 1'b1, 10'h200, 32'h1234_5678);
        expect_out("rst_req", 1'b0, 1'b0, 4'b0111);
        repeat (2) begin
            step(1'b0, 1'b1, 1'b1, 10'h200, 32'h1234_5678);
            expect_out("rst_waking", 1'b0, 1'b0, 4'b0011);
        end
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 1'b0, 1'b0, 4'b1111);
        @(posedge clk);
        #1;
        expect_out("rst_held", 1'b0, 1'b0, 4'b1111);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b0;
        step(1'b0, 1'b1, 1'b0, 10'h000, 32'h0);
        expect_out("post_rst_req", 1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b1, 1'b0, 10'h000, 32'h0);
        expect_out("post_rst_waking", 1'b0, 1'b0, 4'b1110);

        check("write_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
